latch_bist_sequencer: RTL and testbench

//  On-FPGA self-test engine for the latch/flip-flop blocks. It drives S/R/EN/D/dff reset into
//  sr_latch_async, gated_sr_latch and dff_sync, samples their outputs and compares them

---
 rtl/latch_bist_pkg.sv | 41 ++++
 rtl/latch_bist_vector_rom.sv | 36 +++
 rtl/latch_bist_sequencer.sv | 164 ++++++++++++++++
 tb/tb_latch_bist_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/latch_bist_pkg.sv
// ---------------------------------------------------------------------------
// latch_bist_pkg
// Shared definitions for the latch/flip-flop self-test sequencer:
//   - FSM state encoding
//   - bit positions inside the vector ROM word {stim[4:0], exp[2:0], care[2:0]}
//   - number of steps in the test table
// ---------------------------------------------------------------------------
package latch_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam int NUM_STEPS = 12;

    // ROM word layout
    localparam int WORD_W   = 11;
    localparam int STIM_LSB = 6;   // word[10:6] = stim
    localparam int EXP_LSB  = 3;   // word[5:3]  = expected values
    localparam int CARE_LSB = 0;   // word[2:0]  = care mask

    // Stimulus bit positions inside stim[4:0]
    localparam int STIM_S   = 4;
    localparam int STIM_R   = 3;
    localparam int STIM_EN  = 2;
    localparam int STIM_D   = 1;
    localparam int STIM_RST = 0;

    // Expected-value and care-mask bit positions inside exp[2:0] / care[2:0]
    localparam int CARE_SR    = 2;
    localparam int CARE_GATED = 1;
    localparam int CARE_DFF   = 0;

    // Quiescent stimulus: all latch inputs low, flip-flop held in reset
    localparam logic [4:0] STIM_IDLE = 5'b00001;

endpackage

// File: rtl/latch_bist_vector_rom.sv
// ---------------------------------------------------------------------------
// latch_bist_vector_rom
// Combinational table of the 12 self-test steps.
// Ports:
//   step  in  4   step index (0..11; anything else returns all zeros)
//   word  out 11  {stim[4:0]={S,R,EN,D,rst}, exp[2:0]={sr,gated,dff},
//                  care[2:0]={sr,gated,dff}}
// ---------------------------------------------------------------------------
module latch_bist_vector_rom
    import latch_bist_pkg::*;
(
    input  logic [3:0]        step,
    output logic [WORD_W-1:0] word
);

    always_comb begin
        word = '0;
        case (step)
            //                  S R EN D rst   exp      care
            4'd0:  word = {5'b00001, 3'b000, 3'b001};
            4'd1:  word = {5'b10100, 3'b110, 3'b110};
            4'd2:  word = {5'b00100, 3'b110, 3'b110};
            4'd3:  word = {5'b01100, 3'b000, 3'b110};
            4'd4:  word = {5'b00100, 3'b000, 3'b110};
            4'd5:  word = {5'b11100, 3'b000, 3'b000}; // S=R=1 is invalid: nothing checked
            4'd6:  word = {5'b01100, 3'b000, 3'b110};
            4'd7:  word = {5'b10000, 3'b100, 3'b110}; // EN=0: gated latch must hold 0
            4'd8:  word = {5'b01000, 3'b000, 3'b110};
            4'd9:  word = {5'b00010, 3'b001, 3'b001};
            4'd10: word = {5'b00000, 3'b000, 3'b001};
            4'd11: word = {5'b00011, 3'b000, 3'b001}; // reset overrides D=1
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/latch_bist_sequencer.sv
// ---------------------------------------------------------------------------
// latch_bist_sequencer
// Self-test engine for the SR latch, gated SR latch and synchronous DFF.
// Applies each ROM vector, waits SETTLE_CYCLES clocks, then compares the
// synchronized DUT outputs under the care mask.
// Ports:
//   clk, reset_n (sync, active-low)
//   start                      1-cycle request pulse
//   S, R, EN, D, dff_reset     registered stimulus to the DUTs
//   q_sr, qb_sr, q_gated, qb_gated, q_dff   DUT outputs (asynchronous)
//   busy, done, pass           run status; pass valid while done=1
//   err_count [ERR_W]          failing steps, saturating
//   fail_step [4]              first failing step (0 if none)
//   dbg_state [3]              current FSM state (state_e encoding)
// Handshake: start is a request with no ready; it is taken on the clock edge
// where it is high and the FSM is in IDLE or DONE, and dropped otherwise.
// ---------------------------------------------------------------------------
module latch_bist_sequencer
    import latch_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    output logic             S,
    output logic             R,
    output logic             EN,
    output logic             D,
    output logic             dff_reset,
    input  logic             q_sr,
    input  logic             qb_sr,
    input  logic             q_gated,
    input  logic             qb_gated,
    input  logic             q_dff,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_step,
    output logic [2:0]       dbg_state
);

    localparam int              CNT_W     = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [3:0]      LAST_STEP = 4'(NUM_STEPS - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    state_e            state_q, state_d;
    logic [3:0]        step_q, step_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [3:0]        fail_q, fail_d;
    logic [4:0]        stim_q, stim_d;
    // Synchronizer bit order: {q_sr, qb_sr, q_gated, qb_gated, q_dff}
    logic [4:0]        sync1_q, sync1_d, sync2_q, sync2_d;

    logic [WORD_W-1:0] rom_word;
    logic [4:0]        rom_stim;
    logic [2:0]        rom_exp, rom_care;
    logic              sr_bad, gated_bad, dff_bad, mismatch;

    latch_bist_vector_rom u_rom (
        .step (step_q),
        .word (rom_word)
    );

    assign rom_stim = rom_word[STIM_LSB +: 5];
    assign rom_exp  = rom_word[EXP_LSB  +: 3];
    assign rom_care = rom_word[CARE_LSB +: 3];

    // Latch checks also require a true complement on qb.
    assign sr_bad    = rom_care[CARE_SR] &&
                       ((sync2_q[4] != rom_exp[CARE_SR]) || (sync2_q[3] == sync2_q[4]));
    assign gated_bad = rom_care[CARE_GATED] &&
                       ((sync2_q[2] != rom_exp[CARE_GATED]) || (sync2_q[1] == sync2_q[2]));
    assign dff_bad   = rom_care[CARE_DFF] && (sync2_q[0] != rom_exp[CARE_DFF]);
    assign mismatch  = sr_bad || gated_bad || dff_bad;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fail_d  = fail_q;
        stim_d  = stim_q;
        sync1_d = {q_sr, qb_sr, q_gated, qb_gated, q_dff};
        sync2_d = sync1_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_APPLY;
                    step_d  = '0;
                    err_d   = '0;
                    fail_d  = '0;
                end
            end
            ST_APPLY: begin
                stim_d  = rom_stim;
                cnt_d   = '0;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    // err_q==0 identifies the first failure even once saturated later
                    if (err_q == '0) begin
                        fail_d = step_q;
                    end
                end
                if (step_q == LAST_STEP) begin
                    state_d = ST_DONE;
                    // Quiesce the stimulus on entry so it is idle for all of DONE
                    stim_d  = STIM_IDLE;
                end else begin
                    step_d  = step_q + 4'd1;
                    state_d = ST_APPLY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            fail_q  <= '0;
            stim_q  <= STIM_IDLE;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            stim_q  <= stim_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign {S, R, EN, D, dff_reset} = stim_q;
    assign busy      = (state_q == ST_APPLY) || (state_q == ST_SETTLE) || (state_q == ST_CHECK);
    assign done      = (state_q == ST_DONE);
    assign pass      = done && (err_q == '0);
    assign err_count = err_q;
    assign fail_step = fail_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_latch_bist_sequencer.sv
module tb_latch_bist_sequencer;
    import latch_bist_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic start2 = 1'b0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   fault = 0;   // 0 none, 1 q_gated stuck at 1, 2 qb_sr = q_sr

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT 1 (ERR_W=4) with behavioural models ----------------
    logic s1, r1, en1, d1, rst1, busy1, done1, pass1;
    logic [3:0] err1, fs1;
    logic [2:0] st1;
    logic m1_sr = 1'b0, m1_g = 1'b0, m1_dff = 1'b0;
    logic q_sr1, qb_sr1, q_g1, qb_g1, q_dff1;

    always @(s1 or r1) begin
        if (s1 && !r1) m1_sr = 1'b1;
        else if (r1 && !s1) m1_sr = 1'b0;
    end
    always @(s1 or r1 or en1) begin
        if (en1 && s1 && !r1) m1_g = 1'b1;
        else if (en1 && r1 && !s1) m1_g = 1'b0;
    end
    always @(posedge clk) m1_dff <= rst1 ? 1'b0 : d1;

    assign q_sr1  = m1_sr;
    assign qb_sr1 = (fault == 2) ? m1_sr : ~m1_sr;
    assign q_g1   = (fault == 1) ? 1'b1 : m1_g;
    assign qb_g1  = ~m1_g;
    assign q_dff1 = m1_dff;

    latch_bist_sequencer #(.SETTLE_CYCLES(4), .ERR_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .S(s1), .R(r1), .EN(en1), .D(d1), .dff_reset(rst1),
        .q_sr(q_sr1), .qb_sr(qb_sr1), .q_gated(q_g1), .qb_gated(qb_g1), .q_dff(q_dff1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_step(fs1),
        .dbg_state(st1)
    );

    // ---------------- DUT 2 (ERR_W=2), every output inverted ----------------
    logic s2, r2, en2, d2, rst2, busy2, done2, pass2;
    logic [1:0] err2;
    logic [3:0] fs2;
    logic [2:0] st2;
    logic m2_sr = 1'b0, m2_g = 1'b0, m2_dff = 1'b0;

    always @(s2 or r2) begin
        if (s2 && !r2) m2_sr = 1'b1;
        else if (r2 && !s2) m2_sr = 1'b0;
    end
    always @(s2 or r2 or en2) begin
        if (en2 && s2 && !r2) m2_g = 1'b1;
        else if (en2 && r2 && !s2) m2_g = 1'b0;
    end
    always @(posedge clk) m2_dff <= rst2 ? 1'b0 : d2;

    latch_bist_sequencer #(.SETTLE_CYCLES(4), .ERR_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2),
        .S(s2), .R(r2), .EN(en2), .D(d2), .dff_reset(rst2),
        .q_sr(~m2_sr), .qb_sr(m2_sr), .q_gated(~m2_g), .qb_gated(m2_g), .q_dff(~m2_dff),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_step(fs2),
        .dbg_state(st2)
    );

    // ---------------- scoreboard ----------------
    // Expected word: {latency[7:0], pass, err_count[3:0], fail_step[3:0]}
    logic [16:0] exp_q[$];
    logic [16:0] exp2_q[$];

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic logic [16:0] pack_exp(input int lat, input int p, input int e, input int f);
        logic [16:0] w;
        w = {8'(lat), 1'(p), 4'(e), 4'(f)};
        return w;
    endfunction

    logic prev_done1 = 1'b0;
    always @(negedge clk) begin
        logic [16:0] e;
        if (done1 && !prev_done1) begin
            if (exp_q.size() == 0) begin
                chk("dut1_unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("dut1_latency", cyc - start_cyc + 1, int'(e[16:9]));
                chk("dut1_pass", int'(pass1), int'(e[8]));
                chk("dut1_err_count", int'(err1), int'(e[7:4]));
                chk("dut1_fail_step", int'(fs1), int'(e[3:0]));
            end
        end
        prev_done1 = done1;
    end

    logic prev_done2 = 1'b0;
    always @(negedge clk) begin
        logic [16:0] e;
        if (done2 && !prev_done2) begin
            if (exp2_q.size() == 0) begin
                chk("dut2_unexpected_done", 1, 0);
            end else begin
                e = exp2_q.pop_front();
                chk("dut2_latency", cyc - start_cyc + 1, int'(e[16:9]));
                chk("dut2_pass", int'(pass2), int'(e[8]));
                chk("dut2_err_count", int'(err2), int'(e[7:4]));
                chk("dut2_fail_step", int'(fs2), int'(e[3:0]));
            end
        end
        prev_done2 = done2;
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start(input int which);
        @(negedge clk);
        if (which == 1) start = 1'b1; else start2 = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start2 = 1'b0;
        start_cyc = cyc;
        if (which == 1) begin
            chk("start_busy", int'(busy1), 1);
            chk("start_clears_done", int'(done1), 0);
        end else begin
            chk("start2_busy", int'(busy2), 1);
        end
    endtask

    task automatic wait_done(input int which);
        int n = 0;
        while (((which == 1) ? !done1 : !done2) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", int'((which == 1) ? done1 : done2), 1);
        @(negedge clk);
    endtask

    task automatic run(input int which, input int f, input int lat, input int p,
                       input int e, input int fstep);
        fault = f;
        if (which == 1) exp_q.push_back(pack_exp(lat, p, e, fstep));
        else exp2_q.push_back(pack_exp(lat, p, e, fstep));
        pulse_start(which);
        wait_done(which);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk("rst_state", int'(st1), int'(ST_IDLE));
        chk("rst_stim", int'({s1, r1, en1, d1, rst1}), 1);
        chk("rst_busy_done_pass", int'({busy1, done1, pass1}), 0);
        chk("rst_err_count", int'(err1), 0);
        chk("rst_fail_step", int'(fs1), 0);

        // 1: healthy models
        run(1, 0, 73, 1, 0, 0);
        chk("done_stim_idle", int'({s1, r1, en1, d1, rst1}), 1);
        chk("done_state", int'(st1), int'(ST_DONE));

        // 2: q_gated stuck at 1 (restart from DONE)
        run(1, 1, 73, 0, 5, 3);
        // 3: qb_sr follows q_sr
        run(1, 2, 73, 0, 7, 1);

        // 5: start pulse while running step 4 is ignored
        fault = 0;
        exp_q.push_back(pack_exp(73, 1, 0, 0));
        pulse_start(1);
        repeat (26) @(negedge clk);
        chk("midrun_busy", int'(busy1), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1);

        // 4: reset during step 6 SETTLE aborts the run
        fault = 1;
        pulse_start(1);
        repeat (38) @(negedge clk);
        chk("abort_in_settle", int'(st1), int'(ST_SETTLE));
        chk("abort_err_before", int'(err1), 2);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("abort_state", int'(st1), int'(ST_IDLE));
        chk("abort_busy", int'(busy1), 0);
        chk("abort_dff_reset", int'(rst1), 1);
        chk("abort_err_count", int'(err1), 0);
        chk("abort_fail_step", int'(fs1), 0);
        run(1, 0, 73, 1, 0, 0);

        // 6: narrow counter saturates; rerun from DONE
        run(2, 0, 73, 0, 3, 0);
        run(2, 0, 73, 0, 3, 0);

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", exp_q.size() + exp2_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
